mac_ts_tx: RTL and testbench
============================

MAC_TS_TX -- requirements
Module: mac_ts_tx

Interface
REQ-001 Parameter IDLE_GAP, default 0, meaning number of idle cycles (en_n high) inserted between consecutive ordered sets.
REQ-002 Parameter TS_LEN, default 16, meaning symbols per ordered set; only the value 16 is supported.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a burst of ordered sets.
REQ-006 ts_type  input  1  0 = TS1, 1 = TS2; sampled on accepted start.
REQ-007 ts_count  input  16  number of sets in the burst; 16'hFFFF = continuous until stop.
REQ-008 stop  input  1  request to end the burst after the current set.
REQ-009 nfts, dri, tc  input  8 each  N_FTS, data-rate-identifier and training-control fields; sampled on accepted start.
REQ-010 txdata  output  8  symbol byte toward the PHY receiver.
REQ-011 txdatak  output  1  1 = txdata is a K-symbol.
REQ-012 en_n  output  1  active-low symbol-valid.
REQ-013 busy  output  1  high from the cycle after an accepted start until burst end.
REQ-014 done  output  1  one-cycle pulse at burst end.
REQ-015 sets_sent  output  16  count of complete sets transmitted in the current burst.

Function
REQ-016 Symbol constants SHALL be COM = 8'hBC (K), PAD = 8'hF7 (K), TS1ID = 8'h4A (D), TS2ID = 8'h45 (D), taken from the shared defines header.
REQ-017 Set layout SHALL be: sym0 COM, sym1 PAD, sym2 PAD, sym3 nfts, sym4 dri, sym5 tc, sym6-15 TS1ID or TS2ID per ts_type; txdatak = 1 for sym0-2 only.
REQ-018 FSM states SHALL be IDLE, SEND, GAP.
REQ-019 IDLE: start = 1 SHALL latch ts_type/ts_count/nfts/dri/tc, clear sets_sent, and go to SEND; sym0 appears on txdata in the following cycle (latency 1).
REQ-020 start while busy SHALL be ignored, with no effect on latched fields.
REQ-021 SEND: one symbol per cycle with en_n = 0; a symbol index of 0..15 advances each cycle.
REQ-022 On sym15, sets_sent SHALL increment, saturating at 16'hFFFF.
REQ-023 After sym15, the FSM SHALL end the burst if sets_sent has reached ts_count (non-continuous) or stop was seen during the set; otherwise it goes to GAP if IDLE_GAP > 0, else directly to sym0 of the next set with no bubble.
REQ-024 stop SHALL be sticky from its assertion until burst end; a set in progress always completes (no truncated sets).
REQ-025 GAP: en_n = 1, txdata = 0, txdatak = 0 for exactly IDLE_GAP cycles, then SEND sym0; stop during GAP SHALL end the burst at GAP exit without sending another set.
REQ-026 Burst end: the cycle after the last symbol SHALL show done = 1, busy = 0, en_n = 1, FSM in IDLE; start is acceptable in that same cycle.
REQ-027 ts_count = 0 SHALL send no symbols; done pulses one cycle after start, with sets_sent = 0.
REQ-028 Whenever en_n = 1, txdata SHALL be 8'h00 and txdatak 0.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 reset = 1 SHALL, at the next edge, force IDLE, txdata = 0, txdatak = 0, en_n = 1, busy = 0, done = 0, sets_sent = 0, and clear the latched fields and sticky stop.
REQ-031 reset during SEND SHALL abort mid-set with no done pulse; reset has priority over start in the same cycle.

Verification
REQ-032 TS1, ts_count = 1, nfts = 8'h20, dri = 8'h02, tc = 0 -> 16 cycles BC F7 F7 20 02 00 4A x10, k = 1,1,1,0...; done 1 cycle later; sets_sent = 1.
REQ-033 TS2, ts_count = 3, IDLE_GAP = 0 -> 48 contiguous symbols, 45 in sym6-15 of each set, en_n low throughout, sets_sent = 3.
REQ-034 IDLE_GAP = 2, ts_count = 2 -> 16 symbols, 2 cycles en_n = 1 with txdata = 0, 16 symbols, then done.
REQ-035 ts_count = 16'hFFFF, stop pulsed at sym5 of set 4 -> set 4 completes, done pulses, sets_sent = 4.
REQ-036 reset asserted at sym8 of set 1 -> next cycle en_n = 1, busy = 0, no done pulse; a following start sends from sym0.
REQ-037 start re-pulsed during busy, and ts_count = 0 -> re-pulse is ignored (no field change); count = 0 gives done only, with en_n never low.

Source files
------------

// File: rtl/mac_ts_tx.sv
// Ordered-set (TS1/TS2) burst transmitter: sends 16-symbol training sets at one symbol per cycle,
// with an optional idle gap between sets, a count or continuous mode, and a sticky stop.
module mac_ts_tx #(
    parameter int unsigned IDLE_GAP = 0,
    parameter int unsigned TS_LEN   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ts_type,
    input  logic [15:0] ts_count,
    input  logic        stop,
    input  logic [7:0]  nfts,
    input  logic [7:0]  dri,
    input  logic [7:0]  tc,
    output logic [7:0]  txdata,
    output logic        txdatak,
    output logic        en_n,
    output logic        busy,
    output logic        done,
    output logic [15:0] sets_sent
);
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 16;

    localparam logic [7:0] SYM_COM = 8'hBC;
    localparam logic [7:0] SYM_PAD = 8'hF7;
    localparam logic [7:0] SYM_TS1 = 8'h4A;
    localparam logic [7:0] SYM_TS2 = 8'h45;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TS_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((IDLE_GAP == 0) ? 0 : IDLE_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_CONT = '1;
    localparam bit               HAS_GAP  = (IDLE_GAP != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_gap;
    logic             r_type;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_nfts;
    logic [7:0]       r_dri;
    logic [7:0]       r_tc;
    logic             r_stop;

    logic [IDX_W-1:0] w_next_idx;
    logic [7:0]       w_sym_data;
    logic             w_sym_k;
    logic [CNT_W-1:0] w_sent_inc;
    logic             w_count_met;
    logic             w_stop_seen;

    // Symbol that follows the one currently on the wire, plus end-of-set decisions.
    always_comb begin
        w_next_idx  = r_idx + IDX_W'(1);
        w_sym_k     = 1'b0;
        w_sym_data  = r_type ? SYM_TS2 : SYM_TS1;
        case (w_next_idx)
            4'd0: begin
                w_sym_k    = 1'b1;
                w_sym_data = SYM_COM;
            end
            4'd1, 4'd2: begin
                w_sym_k    = 1'b1;
                w_sym_data = SYM_PAD;
            end
            4'd3:    w_sym_data = r_nfts;
            4'd4:    w_sym_data = r_dri;
            4'd5:    w_sym_data = r_tc;
            default: ;
        endcase
        w_sent_inc  = (sets_sent == CNT_CONT) ? sets_sent : sets_sent + CNT_W'(1);
        w_count_met = (r_count != CNT_CONT) && (w_sent_inc >= r_count);
        w_stop_seen = r_stop | stop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_gap     <= '0;
            r_type    <= 1'b0;
            r_count   <= '0;
            r_nfts    <= '0;
            r_dri     <= '0;
            r_tc      <= '0;
            r_stop    <= 1'b0;
            txdata    <= '0;
            txdatak   <= 1'b0;
            en_n      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            sets_sent <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_type    <= ts_type;
                        r_count   <= ts_count;
                        r_nfts    <= nfts;
                        r_dri     <= dri;
                        r_tc      <= tc;
                        r_stop    <= 1'b0;
                        sets_sent <= '0;
                        if (ts_count == '0) begin
                            done <= 1'b1;
                        end else begin
                            r_state <= S_SEND;
                            r_idx   <= '0;
                            busy    <= 1'b1;
                            txdata  <= SYM_COM;
                            txdatak <= 1'b1;
                            en_n    <= 1'b0;
                        end
                    end
                end
                S_SEND: begin
                    if (stop) r_stop <= 1'b1;
                    if (r_idx != LAST_IDX) begin
                        r_idx   <= w_next_idx;
                        txdata  <= w_sym_data;
                        txdatak <= w_sym_k;
                    end else begin
                        sets_sent <= w_sent_inc;
                        if (w_count_met || w_stop_seen) begin
                            r_state <= S_IDLE;
                            r_stop  <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            en_n    <= 1'b1;
                            txdata  <= '0;
                            txdatak <= 1'b0;
                        end else if (HAS_GAP) begin
                            r_state <= S_GAP;
                            r_gap   <= '0;
                            en_n    <= 1'b1;
                            txdata  <= '0;
                            txdatak <= 1'b0;
                        end else begin
                            r_idx   <= '0;
                            txdata  <= SYM_COM;
                            txdatak <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (stop) r_stop <= 1'b1;
                    // Gap exit: a stop seen anywhere in the gap ends the burst instead of a new set.
                    if (r_gap == GAP_LAST) begin
                        if (w_stop_seen) begin
                            r_state <= S_IDLE;
                            r_stop  <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_SEND;
                            r_idx   <= '0;
                            txdata  <= SYM_COM;
                            txdatak <= 1'b1;
                            en_n    <= 1'b0;
                        end
                    end else begin
                        r_gap <= r_gap + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_ts_tx.sv
// Bench for mac_ts_tx: a gap-0 and a gap-2 instance share stimulus; each cycle is compared to a burst-plan model.
module tb_mac_ts_tx;
    localparam int unsigned GAP_B = 2;

    typedef struct packed {
        logic        en_n;
        logic        k;
        logic [7:0]  data;
        logic        busy;
        logic        done;
        logic [15:0] sets;
    } obs_t;

    typedef struct {
        logic        ts_type;
        logic [15:0] count;
        logic [7:0]  nfts;
        logic [7:0]  dri;
        logic [7:0]  tc;
        int          stop_at;
        int          repulse_at;
        int          exp_a;
        int          exp_b;
    } burst_t;

    logic        clk = 1'b0;
    logic        reset, start, ts_type, stop;
    logic [15:0] ts_count;
    logic [7:0]  nfts, dri, tc;

    logic [7:0]  txdata_a, txdata_b;
    logic        txdatak_a, txdatak_b, en_n_a, en_n_b, busy_a, busy_b, done_a, done_b;
    logic [15:0] sets_a, sets_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_ts_tx #(.IDLE_GAP(0), .TS_LEN(16)) dut_a (
        .clk(clk), .reset(reset), .start(start), .ts_type(ts_type), .ts_count(ts_count),
        .stop(stop), .nfts(nfts), .dri(dri), .tc(tc), .txdata(txdata_a), .txdatak(txdatak_a),
        .en_n(en_n_a), .busy(busy_a), .done(done_a), .sets_sent(sets_a)
    );

    mac_ts_tx #(.IDLE_GAP(GAP_B), .TS_LEN(16)) dut_b (
        .clk(clk), .reset(reset), .start(start), .ts_type(ts_type), .ts_count(ts_count),
        .stop(stop), .nfts(nfts), .dri(dri), .tc(tc), .txdata(txdata_b), .txdatak(txdatak_b),
        .en_n(en_n_b), .busy(busy_b), .done(done_b), .sets_sent(sets_b)
    );

    function automatic obs_t obs(input int sel);
        if (sel == 0) return '{en_n_a, txdatak_a, txdata_a, busy_a, done_a, sets_a};
        return '{en_n_b, txdatak_b, txdata_b, busy_b, done_b, sets_b};
    endfunction

    function automatic obs_t idle_obs(input logic dn, input int n);
        return '{1'b1, 1'b0, 8'h00, 1'b0, dn, 16'(n)};
    endfunction

    // Symbol p of a set built from the burst's fields.
    function automatic logic [8:0] ts_sym(input burst_t b, input int p);
        case (p)
            0:       return {1'b1, 8'hBC};
            1, 2:    return {1'b1, 8'hF7};
            3:       return {1'b0, b.nfts};
            4:       return {1'b0, b.dri};
            5:       return {1'b0, b.tc};
            default: return {1'b0, (b.ts_type ? 8'h45 : 8'h4A)};
        endcase
    endfunction

    // Burst plan: set j occupies cycles 1+j*P .. 1+j*P+15 after the start cycle; returns done cycle.
    function automatic int plan(input int gap, input burst_t b, output int n);
        int p, e;
        p = 16 + gap;
        n = 0;
        if (b.count == 16'h0000) return 1;
        for (int j = 0; j < 200; j++) begin
            e = 1 + j * p + 15;
            n = j + 1;
            if (b.count != 16'hFFFF && n >= int'(b.count)) return e + 1;
            if (b.stop_at != 0 && b.stop_at <= e) return e + 1;
            if (gap > 0 && b.stop_at != 0 && b.stop_at <= e + gap) return e + gap + 1;
        end
        return 1 + 200 * p;
    endfunction

    function automatic obs_t exp_obs(input int gap, input burst_t b, input int n, input int dc, input int c);
        int p, j, pos;
        logic [8:0] s;
        if (c == dc) return idle_obs(1'b1, n);
        if (c > dc)  return idle_obs(1'b0, n);
        p   = 16 + gap;
        j   = (c - 1) / p;
        pos = (c - 1) % p;
        if (pos >= 16) return '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'(j + 1)};
        s = ts_sym(b, pos);
        return '{1'b0, s[8], s[7:0], 1'b1, 1'b0, 16'(j)};
    endfunction

    task automatic check(input string name, input int gap, input int c, input obs_t got, input obs_t ex);
        checks++;
        if (got !== ex) begin
            errors++;
            $display("FAIL %s gap%0d cycle %0d: got en_n=%b k=%b data=%h busy=%b done=%b sets=%0d, expected en_n=%b k=%b data=%h busy=%b done=%b sets=%0d",
                     name, gap, c, got.en_n, got.k, got.data, got.busy, got.done, got.sets,
                     ex.en_n, ex.k, ex.data, ex.busy, ex.done, ex.sets);
        end
    endtask

    task automatic check_sets(input string name, input int gap, input logic [15:0] got, input int ex);
        checks++;
        if (got !== 16'(ex)) begin
            errors++;
            $display("FAIL %s_final_sets gap%0d: got %0d expected %0d", name, gap, got, ex);
        end
    endtask

    // Start in the current cycle and follow both instances until the later one shows done.
    task automatic run_burst(input string name, input burst_t b);
        int na, nb, da, db, last;
        da   = plan(0, b, na);
        db   = plan(int'(GAP_B), b, nb);
        last = (da > db) ? da : db;
        start    = 1'b1;
        ts_type  = b.ts_type;
        ts_count = b.count;
        nfts     = b.nfts;
        dri      = b.dri;
        tc       = b.tc;
        stop     = 1'b0;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk); #1;
            check(name, 0, c, obs(0), exp_obs(0, b, na, da, c));
            check(name, int'(GAP_B), c, obs(1), exp_obs(int'(GAP_B), b, nb, db, c));
            start = (c == b.repulse_at);
            if (start) begin
                ts_type  = ~b.ts_type;
                ts_count = 16'd7;
                nfts     = ~b.nfts;
                dri      = ~b.dri;
                tc       = ~b.tc;
            end
            stop = (c == b.stop_at);
        end
        start = 1'b0;
        stop  = 1'b0;
        if (b.exp_a >= 0) check_sets(name, 0, sets_a, b.exp_a);
        if (b.exp_b >= 0) check_sets(name, int'(GAP_B), sets_b, b.exp_b);
    endtask

    task automatic idle_cycle(input string name, input int c);
        @(posedge clk); #1;
        check(name, 0, c, obs(0), idle_obs(1'b0, 0));
        check(name, int'(GAP_B), c, obs(1), idle_obs(1'b0, 0));
    endtask

    burst_t vec[8];
    burst_t rb;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nb, da, db, r, mind;
        //         type  count     nfts   dri    tc     stop rep  a  b
        vec[0] = '{1'b0, 16'd1,    8'h20, 8'h02, 8'h00, 0,   0,   1, 1};
        vec[1] = '{1'b1, 16'd3,    8'h11, 8'h06, 8'h01, 0,   0,   3, 3};
        vec[2] = '{1'b0, 16'd2,    8'h33, 8'h04, 8'h08, 0,   0,   2, 2};
        vec[3] = '{1'b0, 16'hFFFF, 8'h40, 8'h02, 8'h00, 54,  0,   4, 3};
        vec[4] = '{1'b1, 16'd2,    8'h5A, 8'h0E, 8'h02, 0,   5,   2, 2};
        vec[5] = '{1'b0, 16'd0,    8'h77, 8'h01, 8'h01, 0,   0,   0, 0};
        vec[6] = '{1'b1, 16'hFFFF, 8'h81, 8'h02, 8'h04, 20,  0,   2, 2};
        vec[7] = '{1'b0, 16'hFFFF, 8'h99, 8'h0A, 8'h10, 17,  0,   2, 1};

        reset = 1'b1; start = 1'b0; stop = 1'b0; ts_type = 1'b0;
        ts_count = '0; nfts = '0; dri = '0; tc = '0;
        @(posedge clk); @(posedge clk); #1;
        check("reset", 0, 0, obs(0), idle_obs(1'b0, 0));
        check("reset", int'(GAP_B), 0, obs(1), idle_obs(1'b0, 0));
        reset = 1'b0;
        idle_cycle("idle_after_reset", 1);

        for (int i = 0; i < 8; i++) run_burst($sformatf("vec%0d", i), vec[i]);

        // Reset at sym8 of the first set aborts without a done pulse.
        start = 1'b1; ts_type = 1'b0; ts_count = 16'd2; nfts = 8'h20; dri = 8'h02; tc = 8'h00;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        checks++;
        if (txdata_a !== 8'h4A || en_n_a !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_sym8: got data=%h en_n=%b expected data=4a en_n=0", txdata_a, en_n_a);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_mid_set", 0, 0, obs(0), idle_obs(1'b0, 0));
        check("reset_mid_set", int'(GAP_B), 0, obs(1), idle_obs(1'b0, 0));
        reset = 1'b0;
        for (int c = 1; c <= 3; c++) idle_cycle("post_reset_idle", c);

        // Reset wins over a simultaneous start.
        reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        check("reset_over_start", 0, 0, obs(0), idle_obs(1'b0, 0));
        check("reset_over_start", int'(GAP_B), 0, obs(1), idle_obs(1'b0, 0));
        idle_cycle("reset_over_start_idle", 1);
        run_burst("after_reset", vec[0]);

        // Randomized bursts.
        for (int i = 0; i < 12; i++) begin
            rb.ts_type = 1'($urandom_range(0, 1));
            rb.nfts    = 8'($urandom);
            rb.dri     = 8'($urandom);
            rb.tc      = 8'($urandom);
            r          = int'($urandom_range(0, 4));
            rb.count   = (r == 4) ? 16'hFFFF : 16'(r);
            rb.stop_at = (r == 4 || $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 70)) : 0;
            rb.repulse_at = 0;
            rb.exp_a   = -1;
            rb.exp_b   = -1;
            da   = plan(0, rb, na);
            db   = plan(int'(GAP_B), rb, nb);
            mind = (da < db) ? da : db;
            if (mind > 1 && $urandom_range(0, 1) == 1) rb.repulse_at = int'($urandom_range(1, mind - 1));
            run_burst($sformatf("rand%0d", i), rb);
        end

        idle_cycle_end();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic idle_cycle_end();
        @(posedge clk); #1;
        checks++;
        if (done_a !== 1'b0 || done_b !== 1'b0 || en_n_a !== 1'b1 || en_n_b !== 1'b1) begin
            errors++;
            $display("FAIL final_idle: got done=%b/%b en_n=%b/%b expected done=0/0 en_n=1/1",
                     done_a, done_b, en_n_a, en_n_b);
        end
    endtask
endmodule
